// File: rtl/riscv_pkg.sv
// Shared core types for the retirement trace path.
// The TRACE_MEM_EN macro adds load/store address and data to every commit record.
package riscv_pkg;
    localparam int XLEN        = 32;
    localparam int TRACE_SEQ_W = 32;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        instr;
        logic [4:0]             rd_addr;
        logic [XLEN-1:0]        rd_data;
`ifdef TRACE_MEM_EN
        logic [XLEN-1:0]        mem_addr;
        logic [XLEN-1:0]        mem_data;
`endif
    } commit_rec_t;
endpackage

// File: rtl/commit_trace_fifo_if.sv
// Record stream from the trace FIFO to a sink. The master side is the FIFO,
// and the slave side is the sink.
interface commit_trace_fifo_if;
    import riscv_pkg::*;

    logic        rec_valid_o;
    logic        rec_ready_i;
    commit_rec_t rec_o;

    modport master (output rec_valid_o, output rec_o, input rec_ready_i);
    modport slave  (input rec_valid_o, input rec_o, output rec_ready_i);
endinterface

// File: rtl/commit_trace_fifo_sync_fifo.sv
// Generic single-clock FIFO with occupancy count and a synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is kept out of reset so it can map onto RAM.
    // When full, the write to the head slot lands after this cycle's read of that slot.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/commit_trace_fifo.sv
// Captures core retirements into a sequenced trace FIFO. It never stalls the core.
// On overflow it drops records and counts them. Define TRACE_MEM_EN to also capture mem_addr/mem_data.
module commit_trace_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SEQ_W = TRACE_SEQ_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     commit_valid_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               rd_addr_i,
    input  logic [XLEN-1:0]          rd_data_i,
    input  logic [XLEN-1:0]          mem_addr_i,
    input  logic [XLEN-1:0]          mem_data_i,
    input  logic                     flush_i,
    commit_trace_fifo_if.master      trace,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [SEQ_W-1:0]         drop_cnt_o
);
    logic        push, pop, full, empty, drop;
    logic [SEQ_W-1:0] seq_q;
    commit_rec_t rec_in;

    // A flush cycle discards the incoming commit and ignores the sink.
    assign push = commit_valid_i && !flush_i;
    assign pop  = !empty && trace.rec_ready_i && !flush_i;
    assign drop = push && full && !pop;

    assign trace.rec_valid_o = !empty;

    always_comb begin
        rec_in         = '0;
        rec_in.seq     = TRACE_SEQ_W'(seq_q);
        rec_in.pc      = pc_i;
        rec_in.instr   = instr_i;
        rec_in.rd_addr = rd_addr_i;
        rec_in.rd_data = (rd_addr_i == 5'd0) ? '0 : rd_data_i;
`ifdef TRACE_MEM_EN
        rec_in.mem_addr = mem_addr_i;
        rec_in.mem_data = mem_data_i;
`endif
    end

`ifndef TRACE_MEM_EN
    logic unused_mem;
    assign unused_mem = ^{mem_addr_i, mem_data_i};
`endif

    sync_fifo #(
        .WIDTH ($bits(commit_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (flush_i),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (trace.rec_o),
        .full  (full),
        .empty (empty),
        .count (count_o)
    );

    // Every commit consumes a sequence number, so drops and flushes show up as gaps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_q      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (commit_valid_i) seq_q <= seq_q + 1'b1;
            if (flush_i) begin
                overflow_o <= 1'b0;
                drop_cnt_o <= '0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end
endmodule
